ula_seq_param: RTL

Parametrised, clocked successor to the board-level combinational ULA. It is a WIDTH-bit ALU with a start/done handshake.
- Single-cycle ops: add, sub, and, or, xor.
- Multi-cycle ops: iterative shift-add multiply and restoring divide.
- Results and flags are registered and held for the display/BCD path and flag LEDs downstream.

---
 rtl/ula_seq_param.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/ula_seq_param.sv
// WIDTH-bit sequential ALU with a start/done handshake: single-cycle logic/arith ops,
// iterative shift-add multiply and restoring divide, registered result and flags.
module ula_seq_param #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               cin,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               flag_zero,
   output logic               flag_carry,
   output logic               flag_ov,
   output logic               flag_error
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ITER, S_FIN, S_DONE} state_t;

   function automatic logic add_ov(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
      logic signed [WIDTH:0] sx, sy, ss;
      sx = $signed({x[WIDTH-1], x});
      sy = $signed({y[WIDTH-1], y});
      ss = sx + sy + $signed({{WIDTH{1'b0}}, ci});
      return ss[WIDTH] ^ ss[WIDTH-1];
   endfunction

   function automatic logic sub_ov(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic signed [WIDTH:0] sx, sy, ss;
      sx = $signed({x[WIDTH-1], x});
      sy = $signed({y[WIDTH-1], y});
      ss = sx - sy;
      return ss[WIDTH] ^ ss[WIDTH-1];
   endfunction

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic              cin_q, cin_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [RW-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]  rem_q, rem_d, quo_q, quo_d, dvd_q, dvd_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [RW-1:0]     result_q, result_d;
   logic              zero_q, zero_d, carry_q, carry_d, ov_q, ov_d, err_q, err_d;

   logic [WIDTH:0]    add_s, trial, diff;
   logic [WIDTH-1:0]  sub_d;
   logic              qbit;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      cin_d    = cin_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvd_d    = dvd_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ov_d     = ov_q;
      err_d    = err_q;
      add_s    = '0;
      sub_d    = '0;
      trial    = '0;
      diff     = '0;
      qbit     = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            // DONE behaves like IDLE so a new request can launch in the pulse cycle
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (start) begin
               op_d   = op;
               a_d    = a;
               b_d    = b;
               cin_d  = cin;
               cnt_d  = '0;
               acc_d  = '0;
               rem_d  = '0;
               quo_d  = '0;
               dvd_d  = a;
               busy_d = 1'b1;
               if (op == OP_MUL || (op == OP_DIV && b != '0)) state_d = S_ITER;
               else                                            state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            carry_d = 1'b0;
            ov_d    = 1'b0;
            err_d   = 1'b0;
            case (op_q)
               OP_ADD: begin
                  add_s    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
                  result_d = {{(RW-WIDTH-1){1'b0}}, add_s};
                  carry_d  = add_s[WIDTH];
                  ov_d     = add_ov(a_q, b_q, cin_q);
               end
               OP_SUB: begin
                  sub_d    = a_q - b_q;
                  result_d = {{WIDTH{1'b0}}, sub_d};
                  carry_d  = (a_q < b_q);
                  ov_d     = sub_ov(a_q, b_q);
               end
               OP_AND: result_d = {{WIDTH{1'b0}}, a_q & b_q};
               OP_OR:  result_d = {{WIDTH{1'b0}}, a_q | b_q};
               OP_XOR: result_d = {{WIDTH{1'b0}}, a_q ^ b_q};
               default: begin
                  // divide by zero and the invalid opcode both land here
                  result_d = '0;
                  err_d    = 1'b1;
               end
            endcase
            zero_d  = (result_d == '0);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
         end

         S_ITER: begin
            if (op_q == OP_MUL) begin
               if (b_q[cnt_q]) acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
            end else begin
               trial = {rem_q, dvd_q[WIDTH-1]};
               diff  = trial - {1'b0, b_q};
               qbit  = (trial >= {1'b0, b_q});
               rem_d = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], qbit};
               dvd_d = dvd_q << 1;
            end
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_FIN: begin
            result_d = (op_q == OP_MUL) ? acc_q : {rem_q, quo_q};
            zero_d   = (result_d == '0);
            carry_d  = 1'b0;
            ov_d     = 1'b0;
            err_d    = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvd_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ov_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cin_q    <= cin_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvd_q    <= dvd_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ov_q     <= ov_d;
         err_q    <= err_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign result     = result_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign flag_ov    = ov_q;
   assign flag_error = err_q;

endmodule
